snake_motion_engine: RTL and testbench

//  Upstream stage of collision detection: owns the snake position state. On each move tick it

---
 rtl/snake_pkg.sv | 27 ++
 rtl/snake_motion_engine_if.sv | 34 +++
 rtl/snake_motion_engine_move_tick_gen.sv | 60 ++++++
 rtl/snake_motion_engine.sv | 138 +++++++++++++
 tb/tb_snake_motion_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared constants, direction encoding and helpers for the snake motion datapath.
package snake_pkg;

   localparam int COORD_WIDTH    = 11;
   localparam int MAX_LENGTH     = 63;
   localparam int LENGTH_WIDTH   = 6;
   localparam int DISPLAY_WIDTH  = 136;
   localparam int DISPLAY_HEIGHT = 76;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } tick_state_t;

   // Opposite directions share the axis bit and differ only in the sign bit.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/snake_motion_engine_if.sv
// Control inputs and position outputs exchanged between the motion engine and collision logic.
interface snake_motion_engine_if #(
   parameter int COORD_WIDTH  = 11,
   parameter int MAX_LENGTH   = 63,
   parameter int LENGTH_WIDTH = 6
);

   logic                                enable;
   snake_pkg::dir_t                     dir_in;
   logic                                grow;
   logic                                respawn;
   logic [COORD_WIDTH-1:0]              respawn_x;
   logic [COORD_WIDTH-1:0]              respawn_y;
   logic [LENGTH_WIDTH-1:0]             respawn_length;

   logic [COORD_WIDTH-1:0]              head_x;
   logic [COORD_WIDTH-1:0]              head_y;
   logic [COORD_WIDTH*(MAX_LENGTH+1)-1:0] body_x_flat;
   logic [COORD_WIDTH*(MAX_LENGTH+1)-1:0] body_y_flat;
   logic [LENGTH_WIDTH-1:0]             snake_length;
   snake_pkg::dir_t                     dir;
   logic                                move_tick;

   modport master (
      output enable, dir_in, grow, respawn, respawn_x, respawn_y, respawn_length,
      input  head_x, head_y, body_x_flat, body_y_flat, snake_length, dir, move_tick
   );

   modport slave (
      input  enable, dir_in, grow, respawn, respawn_x, respawn_y, respawn_length,
      output head_x, head_y, body_x_flat, body_y_flat, snake_length, dir, move_tick
   );

endinterface

// File: rtl/snake_motion_engine_move_tick_gen.sv
// Move-rate divider: counts 0..TICK_DIV-1 while running and flags the terminal count.
module move_tick_gen
   import snake_pkg::*;
#(
   parameter int TICK_DIV = 2500000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tc
);

   localparam int CNT_W = $clog2(TICK_DIV);

   tick_state_t      state_reg, state_next;
   logic [CNT_W-1:0] count_reg;
   logic             count_en;
   logic             terminal;

   always_comb begin
      state_next = state_reg;
      count_en   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next = ST_RUN;
               count_en   = 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_next = ST_IDLE;
            end else begin
               count_en = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign terminal = (count_reg == CNT_W'(TICK_DIV - 1));
   assign tc       = count_en & terminal & ~clear;

   // Pausing only stops the count; the value is kept so the move cadence resumes in place.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (clear) begin
            count_reg <= '0;
         end else if (count_en) begin
            count_reg <= terminal ? '0 : count_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/snake_motion_engine.sv
// Snake position state: body shift register, head stepping, growth and respawn load.
module snake_motion_engine #(
   parameter int COORD_WIDTH  = snake_pkg::COORD_WIDTH,
   parameter int MAX_LENGTH   = snake_pkg::MAX_LENGTH,
   parameter int LENGTH_WIDTH = snake_pkg::LENGTH_WIDTH,
   parameter int TICK_DIV     = 2500000,
   parameter int START_X      = 68,
   parameter int START_Y      = 38,
   parameter int START_LENGTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   snake_motion_engine_if.slave  bus
);

   import snake_pkg::*;

   localparam int CW = COORD_WIDTH;

   logic [CW-1:0]           body_x_reg [0:MAX_LENGTH];
   logic [CW-1:0]           body_y_reg [0:MAX_LENGTH];
   logic [LENGTH_WIDTH-1:0] length_reg;
   dir_t                    dir_reg, dir_req_reg, dir_ref;
   logic                    grow_pend_reg, move_tick_reg;
   logic                    tc, move_now, grow_now;
   logic [CW-1:0]           head_x_next, head_y_next;
   logic [LENGTH_WIDTH-1:0] respawn_len_clamped;

   move_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_move_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .clear  (bus.respawn),
      .tc     (tc)
   );

   assign move_now = tc & ~bus.respawn;
   assign grow_now = grow_pend_reg | bus.grow;
   // On a move edge the executed direction becomes dir_req, so turns are judged against it.
   assign dir_ref  = move_now ? dir_req_reg : dir_reg;

   always_comb begin
      head_x_next = body_x_reg[0];
      head_y_next = body_y_reg[0];
      case (dir_req_reg)
         DIR_UP:    head_y_next = body_y_reg[0] - 1'b1;
         DIR_DOWN:  head_y_next = body_y_reg[0] + 1'b1;
         DIR_LEFT:  head_x_next = body_x_reg[0] - 1'b1;
         DIR_RIGHT: head_x_next = body_x_reg[0] + 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      respawn_len_clamped = bus.respawn_length;
      if (bus.respawn_length == '0) begin
         respawn_len_clamped = LENGTH_WIDTH'(1);
      end else if (bus.respawn_length > LENGTH_WIDTH'(MAX_LENGTH)) begin
         respawn_len_clamped = LENGTH_WIDTH'(MAX_LENGTH);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         length_reg    <= LENGTH_WIDTH'(START_LENGTH);
         dir_reg       <= DIR_RIGHT;
         dir_req_reg   <= DIR_RIGHT;
         grow_pend_reg <= 1'b0;
         move_tick_reg <= 1'b0;
      end else begin
         move_tick_reg <= move_now;
         if (bus.respawn) begin
            length_reg    <= respawn_len_clamped;
            dir_reg       <= DIR_RIGHT;
            dir_req_reg   <= DIR_RIGHT;
            grow_pend_reg <= 1'b0;
         end else begin
            if (move_now) begin
               dir_reg       <= dir_req_reg;
               grow_pend_reg <= 1'b0;
               if (grow_now && (length_reg < LENGTH_WIDTH'(MAX_LENGTH))) begin
                  length_reg <= length_reg + 1'b1;
               end
            end else if (bus.grow) begin
               grow_pend_reg <= 1'b1;
            end
            if (!is_reverse(bus.dir_in, dir_ref)) begin
               dir_req_reg <= bus.dir_in;
            end
         end
      end
   end

   for (genvar gi = 0; gi <= MAX_LENGTH; gi++) begin : g_slot
      localparam logic [CW-1:0] RST_X = (gi < START_LENGTH) ? CW'(START_X - gi) : '0;
      localparam logic [CW-1:0] RST_Y = (gi < START_LENGTH) ? CW'(START_Y) : '0;

      if (gi == 0) begin : g_head
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               body_x_reg[gi] <= RST_X;
               body_y_reg[gi] <= RST_Y;
            end else if (bus.respawn) begin
               body_x_reg[gi] <= bus.respawn_x;
               body_y_reg[gi] <= bus.respawn_y;
            end else if (move_now) begin
               body_x_reg[gi] <= head_x_next;
               body_y_reg[gi] <= head_y_next;
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               body_x_reg[gi] <= RST_X;
               body_y_reg[gi] <= RST_Y;
            end else if (bus.respawn) begin
               body_x_reg[gi] <= '0;
               body_y_reg[gi] <= '0;
            end else if (move_now) begin
               body_x_reg[gi] <= body_x_reg[gi-1];
               body_y_reg[gi] <= body_y_reg[gi-1];
            end
         end
      end

      assign bus.body_x_flat[CW*gi +: CW] = body_x_reg[gi];
      assign bus.body_y_flat[CW*gi +: CW] = body_y_reg[gi];
   end

   assign bus.head_x       = body_x_reg[0];
   assign bus.head_y       = body_y_reg[0];
   assign bus.snake_length = length_reg;
   assign bus.dir          = dir_reg;
   assign bus.move_tick    = move_tick_reg;

endmodule

// File: tb/tb_snake_motion_engine.sv
// Directed bench for snake_motion_engine with a 4-cycle move period.
module tb_snake_motion_engine;

   import snake_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   snake_motion_engine_if #(.COORD_WIDTH(11), .MAX_LENGTH(63), .LENGTH_WIDTH(6)) bus ();

   snake_motion_engine #(
      .COORD_WIDTH  (11),
      .MAX_LENGTH   (63),
      .LENGTH_WIDTH (6),
      .TICK_DIV     (4),
      .START_X      (68),
      .START_Y      (38),
      .START_LENGTH (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] slot_x(input int i);
      return bus.body_x_flat[11*i +: 11];
   endfunction

   function automatic logic [10:0] slot_y(input int i);
      return bus.body_y_flat[11*i +: 11];
   endfunction

   task automatic tick_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns the number of cycles until move_tick is seen; a missing tick is an error.
   task automatic wait_move(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!bus.move_tick && cycles < 20);
      if (!bus.move_tick) begin
         checks++;
         errors++;
         $display("FAIL wait_move timeout got no move_tick within %0d cycles", cycles);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.enable = 1'b0; bus.dir_in = DIR_RIGHT; bus.grow = 1'b0; bus.respawn = 1'b0;
      bus.respawn_x = '0; bus.respawn_y = '0; bus.respawn_length = '0;
      tick_cycles(2);
      checks++; if (bus.head_x !== 11'd68) begin errors++; $display("FAIL reset_head_x got %0d want 68", bus.head_x); end
      checks++; if (bus.head_y !== 11'd38) begin errors++; $display("FAIL reset_head_y got %0d want 38", bus.head_y); end
      checks++; if (slot_x(1) !== 11'd67 || slot_y(1) !== 11'd38) begin errors++; $display("FAIL reset_slot1 got (%0d,%0d) want (67,38)", slot_x(1), slot_y(1)); end
      checks++; if (slot_x(2) !== 11'd66 || slot_y(2) !== 11'd38) begin errors++; $display("FAIL reset_slot2 got (%0d,%0d) want (66,38)", slot_x(2), slot_y(2)); end
      checks++; if (slot_x(3) !== 11'd0 || slot_y(3) !== 11'd0) begin errors++; $display("FAIL reset_slot3 got (%0d,%0d) want (0,0)", slot_x(3), slot_y(3)); end
      checks++; if (bus.snake_length !== 6'd3) begin errors++; $display("FAIL reset_length got %0d want 3", bus.snake_length); end
      checks++; if (bus.move_tick !== 1'b0) begin errors++; $display("FAIL reset_move_tick got %0b want 0", bus.move_tick); end
      checks++; if (bus.dir !== DIR_RIGHT) begin errors++; $display("FAIL reset_dir got %0d want %0d", bus.dir, DIR_RIGHT); end
      $display("test_reset done");
   endtask

   task automatic test_run_right();
      int ticks;
      ticks = 0;
      reset = 1'b0;
      bus.enable = 1'b1;
      bus.dir_in = DIR_RIGHT;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.move_tick) begin
            ticks++;
            checks++;
            if (c % 4 != 0) begin errors++; $display("FAIL run_tick_spacing got tick at cycle %0d want multiple of 4", c); end
         end
      end
      checks++; if (ticks != 3) begin errors++; $display("FAIL run_tick_count got %0d want 3", ticks); end
      checks++; if (bus.head_x !== 11'd71 || bus.head_y !== 11'd38) begin errors++; $display("FAIL run_head got (%0d,%0d) want (71,38)", bus.head_x, bus.head_y); end
      checks++; if (slot_x(1) !== 11'd70) begin errors++; $display("FAIL run_slot1_x got %0d want 70", slot_x(1)); end
      checks++; if (slot_x(2) !== 11'd69 || slot_y(2) !== 11'd38) begin errors++; $display("FAIL run_slot2 got (%0d,%0d) want (69,38)", slot_x(2), slot_y(2)); end
      checks++; if (bus.snake_length !== 6'd3) begin errors++; $display("FAIL run_length got %0d want 3", bus.snake_length); end
      $display("test_run_right done: %0d moves", ticks);
   endtask

   task automatic test_reverse();
      int cyc;
      bus.dir_in = DIR_LEFT;
      wait_move(cyc);
      checks++; if (bus.head_x !== 11'd72 || bus.head_y !== 11'd38) begin errors++; $display("FAIL reverse_ignored_head got (%0d,%0d) want (72,38)", bus.head_x, bus.head_y); end
      checks++; if (bus.dir !== DIR_RIGHT) begin errors++; $display("FAIL reverse_ignored_dir got %0d want %0d", bus.dir, DIR_RIGHT); end
      bus.dir_in = DIR_UP;
      @(negedge clk);
      bus.dir_in = DIR_LEFT;
      wait_move(cyc);
      checks++; if (bus.head_x !== 11'd72 || bus.head_y !== 11'd37) begin errors++; $display("FAIL double_turn_head got (%0d,%0d) want (72,37)", bus.head_x, bus.head_y); end
      checks++; if (bus.dir !== DIR_UP) begin errors++; $display("FAIL double_turn_dir got %0d want %0d", bus.dir, DIR_UP); end
      bus.dir_in = DIR_RIGHT;
      $display("test_reverse done");
   endtask

   task automatic test_grow();
      int cyc;
      bus.grow = 1'b1;
      @(negedge clk);
      bus.grow = 1'b0;
      wait_move(cyc);
      checks++; if (bus.snake_length !== 6'd4) begin errors++; $display("FAIL grow_length got %0d want 4", bus.snake_length); end
      checks++; if (slot_x(3) !== 11'd71 || slot_y(3) !== 11'd38) begin errors++; $display("FAIL grow_slot3 got (%0d,%0d) want (71,38)", slot_x(3), slot_y(3)); end
      checks++; if (bus.head_x !== 11'd73 || bus.head_y !== 11'd37) begin errors++; $display("FAIL grow_head got (%0d,%0d) want (73,37)", bus.head_x, bus.head_y); end
      // grow asserted on the tick cycle itself
      tick_cycles(3);
      bus.grow = 1'b1;
      @(negedge clk);
      bus.grow = 1'b0;
      checks++; if (bus.move_tick !== 1'b1) begin errors++; $display("FAIL grow_on_tick_move got %0b want 1", bus.move_tick); end
      checks++; if (bus.snake_length !== 6'd5) begin errors++; $display("FAIL grow_on_tick_length got %0d want 5", bus.snake_length); end
      bus.grow = 1'b1;
      tick_cycles(2);
      bus.grow = 1'b0;
      wait_move(cyc);
      checks++; if (bus.snake_length !== 6'd6) begin errors++; $display("FAIL grow_merge_length got %0d want 6", bus.snake_length); end
      checks++; if (bus.head_x !== 11'd75) begin errors++; $display("FAIL grow_merge_head_x got %0d want 75", bus.head_x); end
      $display("test_grow done");
   endtask

   task automatic test_max_length();
      int cyc;
      bus.respawn = 1'b1; bus.respawn_x = 11'd5; bus.respawn_y = 11'd5; bus.respawn_length = 6'd0;
      @(negedge clk);
      checks++; if (bus.snake_length !== 6'd1) begin errors++; $display("FAIL clamp_zero_length got %0d want 1", bus.snake_length); end
      bus.respawn_length = 6'd63;
      @(negedge clk);
      bus.respawn = 1'b0;
      checks++; if (bus.snake_length !== 6'd63) begin errors++; $display("FAIL max_load_length got %0d want 63", bus.snake_length); end
      bus.grow = 1'b1;
      @(negedge clk);
      bus.grow = 1'b0;
      wait_move(cyc);
      checks++; if (bus.snake_length !== 6'd63) begin errors++; $display("FAIL max_grow_length got %0d want 63", bus.snake_length); end
      checks++; if (bus.head_x !== 11'd6 || bus.head_y !== 11'd5) begin errors++; $display("FAIL max_head got (%0d,%0d) want (6,5)", bus.head_x, bus.head_y); end
      $display("test_max_length done");
   endtask

   task automatic test_wrap();
      int cyc;
      bus.respawn = 1'b1; bus.respawn_x = 11'd0; bus.respawn_y = 11'd10; bus.respawn_length = 6'd2;
      @(negedge clk);
      bus.respawn = 1'b0;
      bus.dir_in = DIR_UP;
      wait_move(cyc);
      checks++; if (bus.head_x !== 11'd0 || bus.head_y !== 11'd9) begin errors++; $display("FAIL wrap_up_head got (%0d,%0d) want (0,9)", bus.head_x, bus.head_y); end
      bus.dir_in = DIR_LEFT;
      wait_move(cyc);
      checks++; if (bus.head_x !== 11'd2047 || bus.head_y !== 11'd9) begin errors++; $display("FAIL wrap_left_head got (%0d,%0d) want (2047,9)", bus.head_x, bus.head_y); end
      checks++; if (bus.snake_length !== 6'd2) begin errors++; $display("FAIL wrap_length got %0d want 2", bus.snake_length); end
      checks++; if (slot_x(1) !== 11'd0 || slot_y(1) !== 11'd9) begin errors++; $display("FAIL wrap_slot1 got (%0d,%0d) want (0,9)", slot_x(1), slot_y(1)); end
      $display("test_wrap done");
   endtask

   task automatic test_respawn_on_tick();
      int cyc;
      bus.dir_in = DIR_RIGHT;
      tick_cycles(3);
      bus.respawn = 1'b1; bus.respawn_x = 11'd10; bus.respawn_y = 11'd20; bus.respawn_length = 6'd1;
      @(negedge clk);
      bus.respawn = 1'b0;
      checks++; if (bus.move_tick !== 1'b0) begin errors++; $display("FAIL respawn_move_tick got %0b want 0", bus.move_tick); end
      checks++; if (bus.head_x !== 11'd10 || bus.head_y !== 11'd20) begin errors++; $display("FAIL respawn_head got (%0d,%0d) want (10,20)", bus.head_x, bus.head_y); end
      checks++; if (bus.snake_length !== 6'd1) begin errors++; $display("FAIL respawn_length got %0d want 1", bus.snake_length); end
      checks++; if (slot_x(1) !== 11'd0 || slot_y(1) !== 11'd0) begin errors++; $display("FAIL respawn_slot1 got (%0d,%0d) want (0,0)", slot_x(1), slot_y(1)); end
      checks++; if (bus.dir !== DIR_RIGHT) begin errors++; $display("FAIL respawn_dir got %0d want %0d", bus.dir, DIR_RIGHT); end
      wait_move(cyc);
      checks++; if (cyc != 4) begin errors++; $display("FAIL respawn_counter_clear got %0d cycles want 4", cyc); end
      checks++; if (bus.head_x !== 11'd11 || bus.head_y !== 11'd20) begin errors++; $display("FAIL respawn_next_head got (%0d,%0d) want (11,20)", bus.head_x, bus.head_y); end
      $display("test_respawn_on_tick done");
   endtask

   task automatic test_pause();
      int cyc;
      int ticks;
      ticks = 0;
      tick_cycles(2);
      bus.enable = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.move_tick) ticks++;
      end
      checks++; if (ticks != 0) begin errors++; $display("FAIL pause_ticks got %0d want 0", ticks); end
      checks++; if (bus.head_x !== 11'd11 || bus.head_y !== 11'd20) begin errors++; $display("FAIL pause_head got (%0d,%0d) want (11,20)", bus.head_x, bus.head_y); end
      bus.enable = 1'b1;
      wait_move(cyc);
      checks++; if (cyc != 2) begin errors++; $display("FAIL pause_resume got %0d cycles want 2", cyc); end
      checks++; if (bus.head_x !== 11'd12) begin errors++; $display("FAIL pause_resume_head_x got %0d want 12", bus.head_x); end
      $display("test_pause done");
   endtask

   task automatic test_reset_mid();
      int cyc;
      wait_move(cyc);
      #1 reset = 1'b1;
      #1;
      checks++; if (bus.move_tick !== 1'b0) begin errors++; $display("FAIL mid_reset_move_tick got %0b want 0", bus.move_tick); end
      checks++; if (bus.head_x !== 11'd68 || bus.head_y !== 11'd38) begin errors++; $display("FAIL mid_reset_head got (%0d,%0d) want (68,38)", bus.head_x, bus.head_y); end
      checks++; if (bus.snake_length !== 6'd3) begin errors++; $display("FAIL mid_reset_length got %0d want 3", bus.snake_length); end
      checks++; if (slot_x(1) !== 11'd67 || slot_y(1) !== 11'd38) begin errors++; $display("FAIL mid_reset_slot1 got (%0d,%0d) want (67,38)", slot_x(1), slot_y(1)); end
      @(negedge clk);
      reset = 1'b0;
      $display("test_reset_mid done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_run_right();
      test_reverse();
      test_grow();
      test_max_length();
      test_wrap();
      test_respawn_on_tick();
      test_pause();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
